// File: rtl/mem_access_unit.sv
// Memory-stage access unit: issues aligned byte/half/word accesses on a simple
// req/ack port, stalls upstream while waiting, and packs the MEM/WB bundle.
module mem_access_unit #(
  parameter int ACK_TIMEOUT = 16,
  parameter int DW          = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [DW-1:0]   alu_result,
  input  logic [DW-1:0]   store_data,
  input  logic [2:0]      rd,
  input  logic            reg_write,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [1:0]      size,
  input  logic            load_unsigned,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic [2*DW+4:0] wb_bundle,
  output logic            wb_load,
  output logic            stall,
  output logic            misalign_err,
  output logic            bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] rdata_q, rdata_n;
  logic          bus_err_n;

  logic          mem_op;
  logic          misaligned;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [DW-1:0] load_val;
  logic [DW-1:0] wdata_lane;
  logic [3:0]    be_lane;

  assign mem_op = mem_read | mem_write;

  always_comb begin
    misaligned = 1'b0;
    unique case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = alu_result[0];
      2'b10:   misaligned = |alu_result[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Lane select and extension for loads; write-data replication and byte enables.
  always_comb begin
    byte_sel   = mem_rdata[{alu_result[1:0], 3'b000} +: 8];
    half_sel   = alu_result[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_val   = mem_rdata;
    wdata_lane = store_data;
    be_lane    = 4'b1111;
    unique case (size)
      2'b00: begin
        load_val   = load_unsigned ? {{(DW-8){1'b0}}, byte_sel}
                                   : {{(DW-8){byte_sel[7]}}, byte_sel};
        wdata_lane = {4{store_data[7:0]}};
        be_lane    = 4'b0001 << alu_result[1:0];
      end
      2'b01: begin
        load_val   = load_unsigned ? {{(DW-16){1'b0}}, half_sel}
                                   : {{(DW-16){half_sel[15]}}, half_sel};
        wdata_lane = {2{store_data[15:0]}};
        be_lane    = alu_result[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        load_val   = mem_rdata;
        wdata_lane = store_data;
        be_lane    = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      bus_err <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rdata_q <= rdata_n;
      bus_err <= bus_err_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    rdata_n      = rdata_q;
    bus_err_n    = bus_err;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_be       = '0;
    wb_bundle    = '0;
    wb_load      = 1'b0;
    stall        = 1'b0;
    misalign_err = 1'b0;
    unique case (state)
      S_IDLE: begin
        wb_load = 1'b1;
        if (valid_in) begin
          if (!mem_op) begin
            wb_bundle = {reg_write, 1'b0, {DW{1'b0}}, alu_result, rd};
          end else if (misaligned) begin
            misalign_err = !rst;
            wb_bundle    = {2'b00, {DW{1'b0}}, alu_result, rd};
          end else begin
            wb_load = 1'b0;
            stall   = 1'b1;
            state_n = S_REQ;
            cnt_n   = '0;
          end
        end
      end
      S_REQ: begin
        mem_req   = 1'b1;
        mem_we    = mem_write & ~mem_read;
        mem_addr  = {alu_result[DW-1:2], 2'b00};
        mem_wdata = wdata_lane;
        mem_be    = be_lane;
        stall     = 1'b1;
        // An ack on the final allowed cycle still wins over the timeout.
        if (mem_ack) begin
          rdata_n = mem_read ? load_val : '0;
          state_n = S_DONE;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          bus_err_n = 1'b1;
          rdata_n   = '0;
          state_n   = S_DONE;
          cnt_n     = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DONE: begin
        wb_load   = 1'b1;
        wb_bundle = {reg_write & mem_read, mem_read, rdata_q, alu_result, rd};
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of zero-wait accesses plus
// hand sequences for misalignment, timeout and reset-during-access.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [2:0]  rd;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        load_unsigned;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [68:0] wb_bundle;
  logic        wb_load;
  logic        stall;
  logic        misalign_err;
  logic        bus_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ACK_TIMEOUT(4), .DW(32)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_result(alu_result),
    .store_data(store_data), .rd(rd), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .size(size),
    .load_unsigned(load_unsigned), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_bundle(wb_bundle),
    .wb_load(wb_load), .stall(stall), .misalign_err(misalign_err),
    .bus_err(bus_err)
  );

  typedef struct {
    logic        rd_op;
    logic        wr_op;
    logic [1:0]  size;
    logic        lu;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[10];

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
  } mis_t;

  mis_t mis[4];

  task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdo, input logic wro, input logic [1:0] sz,
                       input logic lu, input logic rw, input logic [31:0] a,
                       input logic [31:0] sd, input logic [2:0] r);
    valid_in      = 1'b1;
    mem_read      = rdo;
    mem_write     = wro;
    size          = sz;
    load_unsigned = lu;
    reg_write     = rw;
    alu_result    = a;
    store_data    = sd;
    rd            = r;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 4'b1000, 32'h0, 32'hFFFFFF80};
    vecs[2] = '{1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 4'b1000, 32'h0, 32'h00000080};
    vecs[3] = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 32'h22,  32'h0, 32'h80017FFF, 4'b1100, 32'h0, 32'hFFFF8001};
    vecs[4] = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 32'h20,  32'h0, 32'h80017FFF, 4'b0011, 32'h0, 32'h00007FFF};
    vecs[5] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'h101, 32'h0, 32'h12345678, 4'b0010, 32'h0, 32'h00000056};
    vecs[6] = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 32'h22,  32'h1234ABCD, 32'hFFFFFFFF, 4'b1100, 32'hABCDABCD, 32'h0};
    vecs[7] = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h102, 32'hAABBCCDD, 32'hFFFFFFFF, 4'b0100, 32'hDDDDDDDD, 32'h0};
    vecs[8] = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h40,  32'hCAFEF00D, 32'hFFFFFFFF, 4'b1111, 32'hCAFEF00D, 32'h0};
    vecs[9] = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 32'h80,  32'h99999999, 32'h11223344, 4'b1111, 32'h0, 32'h11223344};

    mis[0] = '{2'b10, 32'h101};
    mis[1] = '{2'b01, 32'h21};
    mis[2] = '{2'b11, 32'h0};
    mis[3] = '{2'b10, 32'h102};

    rst = 1'b1; valid_in = 1'b0; alu_result = '0; store_data = '0; rd = '0;
    reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = 2'b00;
    load_unsigned = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    tick; tick;
    rst = 1'b0;
    #1;
    chk("reset_mem_req", mem_req, 0);
    chk("reset_bus_err", bus_err, 0);
    chk("reset_stall", stall, 0);
    chk("reset_misalign", misalign_err, 0);
    chk("bubble_load", wb_load, 1);
    chk("bubble_bundle", wb_bundle, 0);

    drive(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 32'h1234, 32'h0, 3'd5);
    #1;
    chk("alu_bundle", wb_bundle, {1'b1, 1'b0, 32'd0, 32'h1234, 3'd5});
    chk("alu_stall", stall, 0);
    chk("alu_load", wb_load, 1);
    tick;
    chk("alu_stays_idle", mem_req, 0);
    valid_in = 1'b0;

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, mis[i].size, 1'b0, 1'b1, mis[i].addr, 32'h0, 3'd2);
      #1;
      chk("mis_err", misalign_err, 1);
      chk("mis_stall", stall, 0);
      chk("mis_load", wb_load, 1);
      chk("mis_bundle", wb_bundle, {2'b00, 32'd0, mis[i].addr, 3'd2});
      valid_in = 1'b0;
      tick;
      chk("mis_no_req", mem_req, 0);
      chk("mis_pulse_end", misalign_err, 0);
    end

    mem_ack = 1'b1; mem_rdata = 32'h13572468;
    tick;
    chk("stray_ack_req", mem_req, 0);
    chk("stray_ack_stall", stall, 0);
    mem_ack = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].rd_op, vecs[i].wr_op, vecs[i].size, vecs[i].lu, vecs[i].rw,
            vecs[i].addr, vecs[i].sdata, 3'(i));
      #1;
      chk("idle_stall", stall, 1);
      chk("idle_load", wb_load, 0);
      chk("idle_req", mem_req, 0);
      tick;
      chk("req_req", mem_req, 1);
      chk("req_stall", stall, 1);
      chk("req_load", wb_load, 0);
      chk("req_addr", mem_addr, vecs[i].addr & 32'hFFFFFFFC);
      chk("req_be", mem_be, vecs[i].be);
      chk("req_we", mem_we, vecs[i].wr_op & ~vecs[i].rd_op);
      if (vecs[i].wr_op && !vecs[i].rd_op)
        chk("req_wdata", mem_wdata, vecs[i].wdata);
      mem_ack = 1'b1; mem_rdata = vecs[i].rdata;
      tick;
      mem_ack = 1'b0; mem_rdata = 32'hA5A5A5A5;
      #1;
      chk("done_load", wb_load, 1);
      chk("done_stall", stall, 0);
      chk("done_req", mem_req, 0);
      chk("done_ctl", wb_bundle[68:67], {vecs[i].rw & vecs[i].rd_op, vecs[i].rd_op});
      chk("done_data", wb_bundle[66:35], vecs[i].data);
      chk("done_alu", wb_bundle[34:0], {vecs[i].addr, 3'(i)});
      valid_in = 1'b0;
      tick;
    end

    drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h10, 32'h0, 3'd1);
    tick;
    for (int k = 0; k < 4; k++) begin
      chk("to_req", mem_req, 1);
      chk("to_no_err_yet", bus_err, 0);
      tick;
    end
    chk("to_done_load", wb_load, 1);
    chk("to_done_data", wb_bundle[66:35], 0);
    chk("to_bus_err", bus_err, 1);
    valid_in = 1'b0;
    tick;
    chk("to_idle", mem_req, 0);
    chk("to_sticky", bus_err, 1);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h20, 32'h0, 3'd4);
    tick;
    chk("to_next_req", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    tick;
    mem_ack = 1'b0;
    #1;
    chk("to_next_data", wb_bundle[66:35], 32'h0BADF00D);
    chk("to_next_sticky", bus_err, 1);
    valid_in = 1'b0;
    tick;

    drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h200, 32'h0, 3'd6);
    tick;
    chk("rr_req1", mem_req, 1);
    tick;
    chk("rr_req2", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 32'h5555AAAA; rst = 1'b1;
    tick;
    rst = 1'b0; mem_ack = 1'b0; valid_in = 1'b0;
    #1;
    chk("rr_idle_req", mem_req, 0);
    chk("rr_stall", stall, 0);
    chk("rr_bundle", wb_bundle, 0);
    chk("rr_bus_err_clr", bus_err, 0);
    tick;
    chk("rr_no_done", wb_bundle, 0);
    chk("rr_still_idle", mem_req, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameters: ACK_TIMEOUT, default 16, maximum cycles in REQ before bus error; DW, default 32, data/address width.
REQ-002 SHALL have ports: clk in 1 clock; rst in 1, reset rst, synchronous, active-high, clock clk.
REQ-003 SHALL have inputs from EX/MEM: valid_in 1 instruction present; alu_result 32 address or ALU value; store_data 32; rd 3 destination register; reg_write 1; mem_read 1; mem_write 1; size 2 (00 byte, 01 half, 10 word); load_unsigned 1.
REQ-004 SHALL have memory-port signals: mem_req out 1; mem_we out 1; mem_addr out 32; mem_wdata out 32; mem_be out 4 byte enables; mem_ack in 1; mem_rdata in 32.
REQ-005 SHALL have outputs: wb_bundle out 69 to MEM/WB Din; wb_load out 1 to MEM/WB Load; stall out 1 to upstream stages; misalign_err out 1 single-cycle pulse; bus_err out 1 sticky.

Function
REQ-006 SHALL pack wb_bundle as [68] reg_write, [67] mem_to_reg, [66:35] load data, [34:3] alu_result, [2:0] rd.
REQ-007 SHALL run a 3-state FSM: IDLE, REQ, DONE.
REQ-008 IDLE, valid_in=0: wb_bundle all zero (bubble), wb_load=1, stall=0.
REQ-009 IDLE, valid_in=1 with no memory op: wb_bundle = {reg_write, 0, 32'd0, alu_result, rd}, wb_load=1, stall=0; state remains IDLE.
REQ-010 IDLE, valid_in=1, mem_read or mem_write, aligned: stall=1, wb_load=0; next state REQ; mem_read has priority if both are set.
REQ-011 Alignment SHALL be: half requires alu_result[0]=0; word requires alu_result[1:0]=00; size=11 is misaligned.
REQ-012 Misaligned access in IDLE: no memory request; misalign_err=1 that cycle; wb_load=1; wb_bundle with reg_write and mem_to_reg forced 0; stall=0.
REQ-013 REQ: mem_req=1; mem_addr = {alu_result[31:2], 2'b00}; mem_we = mem_write and not mem_read; stall=1; wb_load=0; inputs are held stable by upstream.
REQ-014 Store data: byte = store_data[7:0] replicated x4, mem_be one-hot at alu_result[1:0]; half = store_data[15:0] replicated x2, mem_be 0011 (addr[1]=0) or 1100; word = store_data, mem_be 1111. Loads SHALL drive the same mem_be pattern.
REQ-015 REQ with mem_ack=1: capture the selected lane of mem_rdata, zero-extended if load_unsigned else sign-extended, into rdata_q (stores capture 0); next state DONE; timeout counter cleared.
REQ-016 REQ with mem_ack=0: counter increments; when counter reaches ACK_TIMEOUT-1 without ack, set bus_err, rdata_q=0, go DONE.
REQ-017 DONE: mem_req=0; stall=0; wb_load=1; wb_bundle = {reg_write and mem_read, mem_read, rdata_q, alu_result, rd}; next state IDLE.
REQ-018 Load latency SHALL be 2 + (cycles waiting for ack): zero-wait ack gives wb_load in the third cycle after valid_in is presented.
REQ-019 mem_ack outside REQ SHALL be ignored.
REQ-020 bus_err SHALL stay set until rst.

Reset
REQ-021 On rst=1 at a clk edge: state IDLE, counter 0, rdata_q 0, bus_err 0, misalign_err 0; mem_req 0 the following cycle.
REQ-022 Reset during REQ SHALL abandon the access with no capture and no wb_load pulse for that instruction.
REQ-023 rst SHALL override mem_ack arriving in the same cycle.

Verification
REQ-024 Word load at 0x100, mem_rdata=0xDEADBEEF, ack in the first REQ cycle -> DONE bundle[66:35]=0xDEADBEEF, [68:67]=11, wb_load=1 exactly once, stall high for 2 cycles.
REQ-025 Signed byte load at 0x103, mem_rdata=0x80FFFFFF -> mem_be=1000, data 0xFFFFFF80; with load_unsigned=1 -> 0x00000080.
REQ-026 Half store of 0x1234ABCD at 0x22 -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, DONE bundle[68]=0.
REQ-027 Word load at 0x101 -> misalign_err=1 for one cycle, mem_req never asserted, bundle[68:67]=00, wb_load=1.
REQ-028 No ack for ACK_TIMEOUT cycles -> bus_err=1 and remains set, DONE data=0, FSM returns to IDLE and accepts the next instruction.
REQ-029 rst asserted during the second REQ cycle with ack in the same cycle -> IDLE next cycle, rdata_q=0, no wb_load for that instruction.
